ccsds123_bit_reader: RTL
========================

# ccsds123_bit_reader

Receive-side bitstream reader for the CCSDS-123 compressed stream. Accepts the packed BUS_WIDTH-bit words emitted by the compressor's output packer (MSB-first), and serves variable-length field reads to a downstream decoder: raw fields, unary/Golomb prefixes capped at UMAX, and word-alignment flushes. It is the reader counterpart of the packer and sits at the front of the decompression path and in loopback benches.

## Interface
Parameters:
- BUS_WIDTH, 32, packed word width; bit BUS_WIDTH-1 is first in stream
- MAX_LEN, 32, max raw field length; MAX_LEN <= BUS_WIDTH
- UMAX, 16, unary cap; UMAX <= BUS_WIDTH
- LEN_W, $clog2(MAX_LEN+1), width of req_len

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- s_axis_tdata  in  BUS_WIDTH  packed word
- s_axis_tvalid  in  1  word valid
- s_axis_tlast  in  1  final word of packet
- s_axis_tready  out  1  word accepted when tvalid && tready
- req_op  in  2  00 RAW, 01 UNARY, 10 FLUSH, 11 reserved (treated as FLUSH)
- req_len  in  LEN_W  RAW length, 1..MAX_LEN; ignored otherwise
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- out_data  out  MAX_LEN  result, right-aligned, zero-extended
- out_last  out  1  response consumed final bit of tlast packet
- out_err  out  1  request could not be satisfied (underflow)
- out_valid  out  1  response valid
- out_ready  in  1  response taken when out_valid && out_ready

## Operation
- Buffer: 2*BUS_WIDTH-bit left-aligned shift register, fill counter 0..2*BUS_WIDTH, flag last_loaded.
- s_axis_tready = !reset && fill <= BUS_WIDTH && !last_loaded. Accepted word appended directly below the remaining valid bits (after any same-cycle consume); tlast sets last_loaded.
- FSM IDLE -> WAIT -> RESP -> IDLE. req_ready = (state==IDLE) && !reset. Accept captures op/len.
- WAIT evaluates the registered buffer each cycle; when satisfied: consume bits, register out_data/out_last/out_err, go RESP.
  - RAW(n): satisfied when fill >= n; out_data = top n bits; consume n.
  - UNARY: leading-zero count k over top min(fill,UMAX) bits. If a 1 at k < UMAX within fill: out_data = k, consume k+1. If fill >= UMAX and top UMAX all zero: out_data = UMAX (escape), consume UMAX (no terminating 1).
  - FLUSH: satisfied when fill > 0; consume ((fill-1) mod BUS_WIDTH)+1 bits (rest of head word); out_data = 0.
  - Underflow: unsatisfied and last_loaded -> out_err=1, out_data=0, consume all, out_last=1.
- out_last=1 iff last_loaded and fill becomes 0 by this consume.
- RESP holds out_* stable until out_ready; on handshake -> IDLE; if out_last, clear last_loaded (next packet may load).
- req_len 0 or > MAX_LEN: out_err=1, nothing consumed, out_last=0.

## Timing
- Reset: fill=0, last_loaded=0, state IDLE, out_valid=0, out_data=0, out_last=0, out_err=0; s_axis_tready=0 and req_ready=0 while reset high; both 1 the cycle after release.
- Reset mid-operation discards buffer and pending response; no out_valid in cycle after reset.
- Latency: request accepted cycle t, data available -> out_valid at t+2. Word accepted at t is usable in WAIT at t+1.
- Consume and load in same cycle both apply; fill_next = fill - consumed + (load ? BUS_WIDTH : 0).
- No deadlock: WAIT with fill < MAX_LEN always leaves tready high unless last_loaded.
- Back-to-back requests: min 3 cycles/request (IDLE, WAIT, RESP with out_ready high).

## Structure
- ccsds123_pkg: op encodings (OP_RAW, OP_UNARY, OP_FLUSH), FSM state encodings, clog2 function.
- Sub-module ccsds123_leading_zeros: parameterized WIDTH priority encoder, outputs count and all_zero; instantiated with WIDTH=UMAX.
- Single shift-register datapath; no FIFO.

## Test plan
- Word 0xA5000000 (tlast=0); RAW(4), RAW(4) -> 0xA, 0x5; fill 24; tready stays high.
- Word 0x00010000; UNARY -> 15, consumes 16; repeat with 0x00008000 -> 16 (escape), next RAW(1) -> 0.
- RAW(12) spanning words 0x000000AB, 0xC0000000 after RAW(24) -> 0xABC; verify same-cycle load+consume with tvalid held high.
- Word 0xFFFFFFFF tlast=1; RAW(8), FLUSH -> out_data 0, out_last=1; tready low until that handshake, high next cycle.
- Single tlast word, RAW(32) twice -> second response out_err=1, out_last=1, out_data=0; req_len=0 -> out_err=1, fill unchanged.
- Reset asserted in RESP with out_ready low -> out_valid 0 next cycle, fill 0, fresh RAW(8) on 0x12000000 -> 0x12.

Source files
------------

// File: rtl/ccsds123_pkg.sv
// rtl/ccsds123_pkg.sv - shared encodings and helpers for the CCSDS-123 bit reader
package ccsds123_pkg;

  typedef enum logic [1:0] {
    OP_RAW   = 2'b00,
    OP_UNARY = 2'b01,
    OP_FLUSH = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Ceiling log2 usable in parameter expressions
  function automatic int clog2(input int value);
    int r = 0;
    int v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ccsds123_leading_zeros.sv
// rtl/ccsds123_leading_zeros.sv - MSB-first leading-zero counter with all-zero flag
module ccsds123_leading_zeros #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic             all_zero
);

  // Scan from LSB upward so the most significant set bit is the last to write count
  always_comb begin
    count    = CNT_W'(WIDTH);
    all_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        count    = CNT_W'(WIDTH - 1 - i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ccsds123_bit_reader.sv
// rtl/ccsds123_bit_reader.sv - variable-length field reader over a packed MSB-first word stream
module ccsds123_bit_reader
  import ccsds123_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int MAX_LEN   = 32,
  parameter int UMAX      = 16,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  input  logic [1:0]           req_op,
  input  logic [LEN_W-1:0]     req_len,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic [MAX_LEN-1:0]   out_data,
  output logic                 out_last,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int BUF_W  = 2 * BUS_WIDTH;
  localparam int FILL_W = clog2(BUF_W + 1);
  localparam int CNT_W  = clog2(UMAX + 1);
  localparam logic [FILL_W-1:0] BW_F   = FILL_W'(BUS_WIDTH);
  localparam logic [FILL_W-1:0] UMAX_F = FILL_W'(UMAX);
  localparam logic [FILL_W-1:0] MAXL_F = FILL_W'(MAX_LEN);

  // Left-aligned bit buffer; bits below fill_q are kept zero so loads can be OR-ed in
  logic [BUF_W-1:0]   shreg_q;
  logic [FILL_W-1:0]  fill_q;
  logic               last_loaded_q;
  state_e             state_q;
  op_e                op_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] out_data_q;
  logic               out_last_q;
  logic               out_err_q;
  logic               out_valid_q;

  logic               load;
  logic               done;
  logic               bad_len;
  logic               err_c;
  logic               last_c;
  logic [FILL_W-1:0]  consume;
  logic [MAX_LEN-1:0] data_c;
  logic [MAX_LEN-1:0] top_bits;
  logic [FILL_W-1:0]  len_f;
  logic [CNT_W-1:0]   lz_count;
  logic               lz_all_zero;
  logic [FILL_W-1:0]  lz_f;

  assign s_axis_tready = !reset && (fill_q <= BW_F) && !last_loaded_q;
  assign load          = s_axis_tvalid && s_axis_tready;
  assign req_ready     = (state_q == ST_IDLE) && !reset;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign out_err       = out_err_q;
  assign out_valid     = out_valid_q;

  assign top_bits = shreg_q[BUF_W-1 -: MAX_LEN];
  assign len_f    = FILL_W'(len_q);
  assign lz_f     = FILL_W'(lz_count);

  ccsds123_leading_zeros #(
    .WIDTH (UMAX),
    .CNT_W (CNT_W)
  ) u_lz (
    .data     (shreg_q[BUF_W-1 -: UMAX]),
    .count    (lz_count),
    .all_zero (lz_all_zero)
  );

  // Decide in WAIT whether the buffered bits satisfy the pending request and how many to consume
  always_comb begin
    done    = 1'b0;
    bad_len = 1'b0;
    err_c   = 1'b0;
    last_c  = 1'b0;
    consume = '0;
    data_c  = '0;
    if (state_q == ST_WAIT) begin
      case (op_q)
        OP_RAW: begin
          if (len_q == '0 || len_f > MAXL_F) begin
            done    = 1'b1;
            bad_len = 1'b1;
            err_c   = 1'b1;
          end else if (fill_q >= len_f) begin
            done    = 1'b1;
            consume = len_f;
            data_c  = top_bits >> (MAX_LEN - int'(len_q));
          end
        end
        OP_UNARY: begin
          if (!lz_all_zero && lz_f < fill_q) begin
            done    = 1'b1;
            consume = lz_f + FILL_W'(1);
            data_c  = MAX_LEN'(lz_count);
          end else if (lz_all_zero && fill_q >= UMAX_F) begin
            done    = 1'b1;
            consume = UMAX_F;
            data_c  = MAX_LEN'(UMAX);
          end
        end
        default: begin
          // FLUSH and the reserved code drop the remainder of the head word
          if (fill_q != '0) begin
            done    = 1'b1;
            consume = (fill_q > BW_F) ? (fill_q - BW_F) : fill_q;
          end
        end
      endcase
      if (!done && last_loaded_q) begin
        done    = 1'b1;
        err_c   = 1'b1;
        consume = fill_q;
        data_c  = '0;
      end
      last_c = done && !bad_len && last_loaded_q && (fill_q == consume);
    end
  end

  // Buffer, fill count, packet-end flag and the request/response FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q       <= '0;
      fill_q        <= '0;
      last_loaded_q <= 1'b0;
      state_q       <= ST_IDLE;
      op_q          <= OP_RAW;
      len_q         <= '0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_err_q     <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      if (load || done) begin
        shreg_q <= (shreg_q << consume)
                 | (load ? ({s_axis_tdata, {BUS_WIDTH{1'b0}}} >> (fill_q - consume)) : '0);
        fill_q  <= fill_q - consume + (load ? BW_F : '0);
      end
      if (load && s_axis_tlast) begin
        last_loaded_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= op_e'(req_op);
            len_q   <= req_len;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done) begin
            out_data_q  <= data_c;
            out_last_q  <= last_c;
            out_err_q   <= err_c;
            out_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              last_loaded_q <= 1'b0;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
